gcn_transform_sequencer: RTL and testbench

//  Drives the combinational dot-product datapath for the GCN transform stage (output = F x W).

---
 rtl/gcn_pkg.sv | 17 +
 rtl/gcn_index_counter.sv | 52 +++++
 rtl/gcn_transform_sequencer.sv | 107 ++++++++++
 tb/tb_gcn_transform_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gcn_pkg.sv
// Shared sizes, derived address widths and sequencer state encoding for the GCN transform stage.
package gcn_pkg;
  localparam int FEATURE_WIDTH  = 5;
  localparam int WEIGHT_WIDTH   = 5;
  localparam int DOT_PROD_WIDTH = 16;
  localparam int FEATURE_ROWS   = 6;
  localparam int FEATURE_COLS   = 96;
  localparam int WEIGHT_COLS    = 3;

  localparam int F_ADDR_W = $clog2(FEATURE_ROWS);
  localparam int W_ADDR_W = $clog2(WEIGHT_COLS);
  localparam int O_ADDR_W = $clog2(FEATURE_ROWS * WEIGHT_COLS);

  typedef enum logic [2:0] {
    IDLE, LOAD_W, CAP_W, LOAD_F, CAP_F, CALC, WRITE, DONE
  } state_e;
endpackage

// File: rtl/gcn_index_counter.sv
// Nested row (i) / weight-column (j) counter; i runs fastest, output address is row-major i*WEIGHT_COLS+j.
module gcn_index_counter
  import gcn_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                adv,
  output logic [F_ADDR_W-1:0] i,
  output logic [W_ADDR_W-1:0] j,
  output logic                i_last,
  output logic                j_last,
  output logic [O_ADDR_W-1:0] out_addr
);

  logic [F_ADDR_W-1:0] i_d, i_q;
  logic [W_ADDR_W-1:0] j_d, j_q;

  assign i_last   = (i_q == F_ADDR_W'(FEATURE_ROWS - 1));
  assign j_last   = (j_q == W_ADDR_W'(WEIGHT_COLS - 1));
  assign i        = i_q;
  assign j        = j_q;
  assign out_addr = O_ADDR_W'(i_q) * O_ADDR_W'(WEIGHT_COLS) + O_ADDR_W'(j_q);

  // j is left at its last value after the final write; clr rewinds both for the next run
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (clr) begin
      i_d = '0;
      j_d = '0;
    end else if (adv) begin
      if (i_last) begin
        i_d = '0;
        if (!j_last) j_d = j_q + 1'b1;
      end else begin
        i_d = i_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

endmodule

// File: rtl/gcn_transform_sequencer.sv
// Sequences weight-column / feature-row reads into the external dot-product unit and writes each product to the output map.
module gcn_transform_sequencer
  import gcn_pkg::*;
(
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        start,
  output logic [W_ADDR_W-1:0]                         read_weight_addr,
  output logic                                        enable_read_weight,
  input  logic [FEATURE_COLS-1:0][WEIGHT_WIDTH-1:0]   weight_data,
  output logic [F_ADDR_W-1:0]                         read_feature_addr,
  output logic                                        enable_read_feature,
  input  logic [FEATURE_COLS-1:0][FEATURE_WIDTH-1:0]  feature_data,
  output logic [FEATURE_COLS-1:0][FEATURE_WIDTH-1:0]  dp_feature,
  output logic [FEATURE_COLS-1:0][WEIGHT_WIDTH-1:0]   dp_weight,
  input  logic [DOT_PROD_WIDTH-1:0]                   dp_product,
  output logic [O_ADDR_W-1:0]                         output_addr,
  output logic                                        output_wr_en,
  output logic [DOT_PROD_WIDTH-1:0]                   output_data,
  output logic                                        done
);

  state_e state_d, state_q;
  logic [FEATURE_COLS-1:0][FEATURE_WIDTH-1:0] dp_feature_d, dp_feature_q;
  logic [FEATURE_COLS-1:0][WEIGHT_WIDTH-1:0]  dp_weight_d, dp_weight_q;
  logic [DOT_PROD_WIDTH-1:0]                  output_data_d, output_data_q;

  logic                clr, adv, i_last, j_last;
  logic [F_ADDR_W-1:0] idx_i;
  logic [W_ADDR_W-1:0] idx_j;
  logic [O_ADDR_W-1:0] idx_addr;

  assign clr = (state_q == IDLE);

  gcn_index_counter u_idx (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .adv      (adv),
    .i        (idx_i),
    .j        (idx_j),
    .i_last   (i_last),
    .j_last   (j_last),
    .out_addr (idx_addr)
  );

  always_comb begin
    state_d       = state_q;
    dp_feature_d  = dp_feature_q;
    dp_weight_d   = dp_weight_q;
    output_data_d = output_data_q;
    adv           = 1'b0;
    unique case (state_q)
      IDLE:   if (start) state_d = LOAD_W;
      LOAD_W: state_d = CAP_W;
      CAP_W: begin
        dp_weight_d = weight_data;
        state_d     = LOAD_F;
      end
      LOAD_F: state_d = CAP_F;
      CAP_F: begin
        dp_feature_d = feature_data;
        state_d      = CALC;
      end
      // product is taken at full port width, so overflow wraps modulo 2^DOT_PROD_WIDTH
      CALC: begin
        output_data_d = dp_product;
        state_d       = WRITE;
      end
      WRITE: begin
        adv = 1'b1;
        if (!i_last)      state_d = LOAD_F;
        else if (!j_last) state_d = LOAD_W;
        else              state_d = DONE;
      end
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      dp_feature_q  <= '0;
      dp_weight_q   <= '0;
      output_data_q <= '0;
    end else begin
      state_q       <= state_d;
      dp_feature_q  <= dp_feature_d;
      dp_weight_q   <= dp_weight_d;
      output_data_q <= output_data_d;
    end
  end

  // Moore outputs: strobes are single-state pulses and addresses are forced to 0 outside them
  assign enable_read_weight  = (state_q == LOAD_W);
  assign read_weight_addr    = enable_read_weight ? idx_j : '0;
  assign enable_read_feature = (state_q == LOAD_F);
  assign read_feature_addr   = enable_read_feature ? idx_i : '0;
  assign output_wr_en        = (state_q == WRITE);
  assign output_addr         = output_wr_en ? idx_addr : '0;
  assign output_data         = output_data_q;
  assign dp_feature          = dp_feature_q;
  assign dp_weight           = dp_weight_q;
  assign done                = (state_q == DONE);

endmodule

// File: tb/tb_gcn_transform_sequencer.sv
// Directed bench: memory and dot-product models around the sequencer, table of full-run vectors plus corner sequences.
module tb_gcn_transform_sequencer;
  import gcn_pkg::*;

  logic                                        clk;
  logic                                        rst_n;
  logic                                        start;
  logic [W_ADDR_W-1:0]                         read_weight_addr;
  logic                                        enable_read_weight;
  logic [FEATURE_COLS-1:0][WEIGHT_WIDTH-1:0]   weight_data;
  logic [F_ADDR_W-1:0]                         read_feature_addr;
  logic                                        enable_read_feature;
  logic [FEATURE_COLS-1:0][FEATURE_WIDTH-1:0]  feature_data;
  logic [FEATURE_COLS-1:0][FEATURE_WIDTH-1:0]  dp_feature;
  logic [FEATURE_COLS-1:0][WEIGHT_WIDTH-1:0]   dp_weight;
  logic [DOT_PROD_WIDTH-1:0]                   dp_product;
  logic [O_ADDR_W-1:0]                         output_addr;
  logic                                        output_wr_en;
  logic [DOT_PROD_WIDTH-1:0]                   output_data;
  logic                                        done;

  gcn_transform_sequencer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .read_weight_addr    (read_weight_addr),
    .enable_read_weight  (enable_read_weight),
    .weight_data         (weight_data),
    .read_feature_addr   (read_feature_addr),
    .enable_read_feature (enable_read_feature),
    .feature_data        (feature_data),
    .dp_feature          (dp_feature),
    .dp_weight           (dp_weight),
    .dp_product          (dp_product),
    .output_addr         (output_addr),
    .output_wr_en        (output_wr_en),
    .output_data         (output_data),
    .done                (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memories with one-cycle read latency
  logic [FEATURE_COLS-1:0][WEIGHT_WIDTH-1:0]  wmem [WEIGHT_COLS];
  logic [FEATURE_COLS-1:0][FEATURE_WIDTH-1:0] fmem [FEATURE_ROWS];

  always @(posedge clk) begin
    if (enable_read_weight)  weight_data  <= wmem[int'(read_weight_addr)];
    if (enable_read_feature) feature_data <= fmem[int'(read_feature_addr)];
  end

  // external combinational dot-product unit, truncated to the port width
  function automatic logic [DOT_PROD_WIDTH-1:0] dot(
    input logic [FEATURE_COLS-1:0][FEATURE_WIDTH-1:0] f,
    input logic [FEATURE_COLS-1:0][WEIGHT_WIDTH-1:0]  w);
    logic [31:0] acc;
    acc = '0;
    for (int k = 0; k < FEATURE_COLS; k++) acc += 32'(f[k]) * 32'(w[k]);
    return acc[DOT_PROD_WIDTH-1:0];
  endfunction

  assign dp_product = dot(dp_feature, dp_weight);

  int checks = 0;
  int failures = 0;
  int wcount = 0;
  int addr_viol = 0;
  int log_addr [256];
  int log_data [256];

  always @(posedge clk) begin
    #1;
    if (output_wr_en && wcount < 256) begin
      log_addr[wcount] = int'(output_addr);
      log_data[wcount] = int'(output_data);
      wcount++;
    end
    if (!enable_read_weight && read_weight_addr != '0) addr_viol++;
    if (!enable_read_feature && read_feature_addr != '0) addr_viol++;
    if (!output_wr_en && output_addr != '0) addr_viol++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_en_w"},   longint'(enable_read_weight), 0);
    chk({tag, "_addr_w"}, longint'(read_weight_addr), 0);
    chk({tag, "_en_f"},   longint'(enable_read_feature), 0);
    chk({tag, "_addr_f"}, longint'(read_feature_addr), 0);
    chk({tag, "_dp_f_nz"}, longint'(|dp_feature), 0);
    chk({tag, "_dp_w_nz"}, longint'(|dp_weight), 0);
    chk({tag, "_wr_en"},  longint'(output_wr_en), 0);
    chk({tag, "_oaddr"},  longint'(output_addr), 0);
    chk({tag, "_odata"},  longint'(output_data), 0);
    chk({tag, "_done"},   longint'(done), 0);
  endtask

  // wpat: 0 all ones, 1 all 31, 2 column j = j+1; fpat: 0 row r = r, 1 all 31, 2 all 2
  task automatic load_mem(input int wpat, input int fpat);
    for (int c = 0; c < WEIGHT_COLS; c++)
      for (int k = 0; k < FEATURE_COLS; k++)
        wmem[c][k] = (wpat == 0) ? 5'd1 : (wpat == 1) ? 5'd31 : 5'(c + 1);
    for (int r = 0; r < FEATURE_ROWS; r++)
      for (int k = 0; k < FEATURE_COLS; k++)
        fmem[r][k] = (fpat == 0) ? 5'(r) : (fpat == 1) ? 5'd31 : 5'd2;
  endtask

  function automatic int exp_val(input int i, input int j);
    int acc;
    acc = 0;
    for (int k = 0; k < FEATURE_COLS; k++) acc += int'(fmem[i][k]) * int'(wmem[j][k]);
    return acc % 65536;
  endfunction

  // starts a run, waits for done (bounded), then checks latency, write order and data
  task automatic do_run(input string tag, input bit toggle, input int spot_addr, input int spot_data);
    int cyc, base, found, ii, jj;
    base = wcount;
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (toggle && !done) start = cyc[0];
    end
    chk({tag, "_done_cycle"}, cyc, 79);
    chk({tag, "_write_count"}, wcount - base, 18);
    for (int n = 0; n < 18; n++) begin
      jj = n / FEATURE_ROWS;
      ii = n % FEATURE_ROWS;
      chk($sformatf("%s_addr%0d", tag, n), log_addr[base + n], ii * WEIGHT_COLS + jj);
      chk($sformatf("%s_data%0d", tag, n), log_data[base + n], exp_val(ii, jj));
    end
    found = 0;
    for (int n = 0; n < 18; n++)
      if (log_addr[base + n] == spot_addr) begin
        found++;
        chk($sformatf("%s_spot%0d", tag, spot_addr), log_data[base + n], spot_data);
      end
    chk({tag, "_spot_found"}, found, 1);
  endtask

  typedef struct {
    int wpat;
    int fpat;
    bit toggle;
    int spot_addr;
    int spot_data;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int base;
    vecs[0] = '{0, 0, 1'b0, 15, 480};
    vecs[1] = '{1, 1, 1'b0, 7, 26720};
    vecs[2] = '{2, 2, 1'b0, 17, 576};
    vecs[3] = '{0, 0, 1'b1, 4, 96};

    rst_n = 1'b0;
    start = 1'b0;
    load_mem(0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero_outputs("idle");

    for (int v = 0; v < 4; v++) begin
      load_mem(vecs[v].wpat, vecs[v].fpat);
      do_run($sformatf("vec%0d", v), vecs[v].toggle, vecs[v].spot_addr, vecs[v].spot_data);
      start = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_idle_after", v), longint'(done), 0);
    end

    // start held past done: stays DONE, no writes, then one-cycle return to IDLE and a clean rerun
    load_mem(0, 0);
    do_run("hold", 1'b0, 15, 480);
    base = wcount;
    repeat (5) @(negedge clk);
    chk("hold_done_high", longint'(done), 1);
    chk("hold_no_writes", wcount - base, 0);
    start = 1'b0;
    @(negedge clk);
    chk("hold_drop_idle", longint'(done), 0);
    do_run("rerun", 1'b0, 15, 480);
    start = 1'b0;
    @(negedge clk);

    // reset asserted during CALC of i=2, j=1 (cycle 39 after the start edge)
    base = wcount;
    start = 1'b1;
    repeat (39) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    @(posedge clk);
    #2;
    chk("midrst_writes_before", wcount - base, 8);
    @(negedge clk);
    rst_n = 1'b1;
    do_run("after_rst", 1'b0, 15, 480);
    start = 1'b0;
    @(negedge clk);

    chk("addr_zero_when_disabled", addr_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
